// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwarding, A/B operand and ALU opcode selection, valid/ready register.
// Optional macro ALU_FWD_EN enables the EX/MEM and MEM/WB forwarding network.
module alu_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op_class,
  input  logic [2:0]            funct3,
  input  logic                  funct7_b30,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic [XLEN-1:0]       pc,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  exm_wr_en,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [XLEN-1:0]       exm_data,
  input  logic                  mwb_wr_en,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]       mwb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       a_out,
  output logic [XLEN-1:0]       b_out,
  output logic [3:0]            alu_op_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [XLEN-1:0]       rs2_fwd_out,
  output logic                  illegal_out
);

  typedef enum logic [2:0] {
    OPC_R_ALU  = 3'd0,
    OPC_I_ALU  = 3'd1,
    OPC_LUI    = 3'd2,
    OPC_AUIPC  = 3'd3,
    OPC_MEM    = 3'd4,
    OPC_BRANCH = 3'd5,
    OPC_RSV6   = 3'd6,
    OPC_RSV7   = 3'd7
  } op_class_e;

  op_class_e             cls;
  logic [XLEN-1:0]       r1, r2;
  logic [XLEN-1:0]       a_sel, b_sel;
  logic [3:0]            op_sel;
  logic                  ill_sel;
  logic                  load;

  logic                  valid_d, valid_q;
  logic [XLEN-1:0]       a_d, a_q, b_d, b_q, rs2f_d, rs2f_q;
  logic [3:0]            op_d, op_q;
  logic [REG_ADDR_W-1:0] rd_d, rd_q;
  logic                  ill_d, ill_q;

  assign cls      = op_class_e'(op_class);
  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

`ifdef ALU_FWD_EN
  // EX/MEM is the younger producer, so it is checked first; x0 never forwards.
  always_comb begin
    r1 = rs1_data;
    r2 = rs2_data;
    if (exm_wr_en && (exm_rd != '0) && (exm_rd == rs1_addr))
      r1 = exm_data;
    else if (mwb_wr_en && (mwb_rd != '0) && (mwb_rd == rs1_addr))
      r1 = mwb_data;
    if (exm_wr_en && (exm_rd != '0) && (exm_rd == rs2_addr))
      r2 = exm_data;
    else if (mwb_wr_en && (mwb_rd != '0) && (mwb_rd == rs2_addr))
      r2 = mwb_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1_addr, rs2_addr, exm_wr_en, exm_rd, exm_data,
                        mwb_wr_en, mwb_rd, mwb_data};
  always_comb begin
    r1 = rs1_data;
    r2 = rs2_data;
  end
`endif

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    op_sel  = 4'b0000;
    ill_sel = 1'b0;
    unique case (cls)
      OPC_R_ALU: begin
        a_sel  = r1;
        b_sel  = r2;
        op_sel = {funct7_b30, funct3};
      end
      OPC_I_ALU: begin
        // Bit 30 only matters for SRAI; for ADDI it is part of the immediate.
        a_sel  = r1;
        b_sel  = imm;
        op_sel = {funct7_b30 & (funct3 == 3'b101), funct3};
      end
      OPC_LUI: b_sel = imm;
      OPC_AUIPC: begin
        a_sel = pc;
        b_sel = imm;
      end
      OPC_MEM: begin
        a_sel = r1;
        b_sel = imm;
      end
      OPC_BRANCH: begin
        a_sel = r1;
        b_sel = r2;
        unique case (funct3[2:1])
          2'b00:   op_sel = 4'b1000;
          2'b10:   op_sel = 4'b0010;
          2'b11:   op_sel = 4'b0011;
          default: ill_sel = 1'b1;
        endcase
      end
      default: ill_sel = 1'b1;
    endcase
  end

  always_comb begin
    valid_d = flush ? 1'b0 : (load || (valid_q && !out_ready));
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs2f_d  = rs2f_q;
    ill_d   = ill_q;
    if (load) begin
      a_d    = a_sel;
      b_d    = b_sel;
      op_d   = op_sel;
      rd_d   = rd_in;
      rs2f_d = r2;
      ill_d  = ill_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rs2f_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs2f_q  <= rs2f_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid   = valid_q;
  assign a_out       = a_q;
  assign b_out       = b_q;
  assign alu_op_out  = op_q;
  assign rd_out      = rd_q;
  assign rs2_fwd_out = rs2f_q;
  assign illegal_out = ill_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Table-driven bench for alu_operand_stage with an expected-result queue; follows ALU_FWD_EN.
module tb_alu_operand_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;
`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [2:0]      op_class, funct3;
  logic            funct7_b30;
  logic [RW-1:0]   rs1_addr, rs2_addr, rd_in, exm_rd, mwb_rd, rd_out;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, pc, exm_data, mwb_data;
  logic            exm_wr_en, mwb_wr_en, flush, out_valid, out_ready, illegal_out;
  logic [XLEN-1:0] a_out, b_out, rs2_fwd_out;
  logic [3:0]      alu_op_out;

  alu_operand_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .funct3(funct3), .funct7_b30(funct7_b30),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .rd_in(rd_in),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .alu_op_out(alu_op_out), .rd_out(rd_out),
    .rs2_fwd_out(rs2_fwd_out), .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      cls;
    logic [2:0]      f3;
    logic            b30;
    logic [RW-1:0]   ra1, ra2;
    logic [XLEN-1:0] d1, d2, imm, pc;
    logic [RW-1:0]   rd;
    logic            exw;
    logic [RW-1:0]   exrd;
    logic [XLEN-1:0] exd;
    logic            mww;
    logic [RW-1:0]   mwrd;
    logic [XLEN-1:0] mwd;
    logic [XLEN-1:0] ea, eb, er2;
    logic [3:0]      eop;
    logic            eill;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] a, b, r2;
    logic [3:0]      op;
    logic [RW-1:0]   rd;
    logic            ill;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    op_class = v.cls;   funct3 = v.f3;     funct7_b30 = v.b30;
    rs1_addr = v.ra1;   rs2_addr = v.ra2;  rs1_data = v.d1; rs2_data = v.d2;
    imm = v.imm;        pc = v.pc;         rd_in = v.rd;
    exm_wr_en = v.exw;  exm_rd = v.exrd;   exm_data = v.exd;
    mwb_wr_en = v.mww;  mwb_rd = v.mwrd;   mwb_data = v.mwd;
  endtask

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.a = v.ea; e.b = v.eb; e.r2 = v.er2; e.op = v.eop; e.rd = v.rd; e.ill = v.eill;
    return e;
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_scoreboard actual=output required=empty", tag);
      end else begin
        e = sb.pop_front();
        chk({tag, "_a"},   a_out,              e.a);
        chk({tag, "_b"},   b_out,              e.b);
        chk({tag, "_r2"},  rs2_fwd_out,        e.r2);
        chk({tag, "_op"},  32'(alu_op_out),    32'(e.op));
        chk({tag, "_rd"},  32'(rd_out),        32'(e.rd));
        chk({tag, "_ill"}, 32'(illegal_out),   32'(e.ill));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid),   32'd0);
    chk({tag, "_a"},     a_out,            32'd0);
    chk({tag, "_b"},     b_out,            32'd0);
    chk({tag, "_op"},    32'(alu_op_out),  32'd0);
    chk({tag, "_rd"},    32'(rd_out),      32'd0);
    chk({tag, "_r2"},    rs2_fwd_out,      32'd0);
    chk({tag, "_ill"},   32'(illegal_out), 32'd0);
  endtask

  initial begin
    // fields: cls f3 b30 ra1 ra2 d1 d2 imm pc rd | exw exrd exd mww mwrd mwd | ea eb er2 eop eill
    tbl[0]  = '{3'd0, 3'b000, 1'b1, 5'd1, 5'd2, 32'd10, 32'd3, 32'd0, 32'd0, 5'd3,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd10, 32'd3, 32'd3, 4'b1000, 1'b0};
    tbl[1]  = '{3'd0, 3'b000, 1'b0, 5'd4, 5'd6, 32'h7fffffff, 32'd1, 32'h5, 32'h40, 5'd7,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h7fffffff, 32'd1, 32'd1, 4'b0000, 1'b0};
    tbl[2]  = '{3'd1, 3'b101, 1'b1, 5'd8, 5'd9, 32'h80000000, 32'h99, 32'd4, 32'h0, 5'd10,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h80000000, 32'd4, 32'h99, 4'b1101, 1'b0};
    tbl[3]  = '{3'd1, 3'b000, 1'b1, 5'd8, 5'd9, 32'h100, 32'h99, 32'hfffffff0, 32'h0, 5'd11,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h100, 32'hfffffff0, 32'h99, 4'b0000, 1'b0};
    tbl[4]  = '{3'd2, 3'b111, 1'b1, 5'd1, 5'd2, 32'hdead, 32'hbeef, 32'h12345000, 32'h80, 5'd12,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h0, 32'h12345000, 32'hbeef, 4'b0000, 1'b0};
    tbl[5]  = '{3'd3, 3'b010, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2, 32'h2000, 32'h1000, 5'd13,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h1000, 32'h2000, 32'h2, 4'b0000, 1'b0};
    tbl[6]  = '{3'd4, 3'b010, 1'b1, 5'd3, 5'd4, 32'h3000, 32'h55, 32'h8, 32'h0, 5'd14,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h3000, 32'h8, 32'h55, 4'b0000, 1'b0};
    tbl[7]  = '{3'd5, 3'b000, 1'b0, 5'd1, 5'd2, 32'h5, 32'h6, 32'h40, 32'h200, 5'd0,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h5, 32'h6, 32'h6, 4'b1000, 1'b0};
    tbl[8]  = '{3'd5, 3'b101, 1'b0, 5'd1, 5'd2, 32'h7, 32'h8, 32'h40, 32'h204, 5'd0,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h7, 32'h8, 32'h8, 4'b0010, 1'b0};
    tbl[9]  = '{3'd5, 3'b110, 1'b0, 5'd1, 5'd2, 32'h9, 32'ha, 32'h40, 32'h208, 5'd0,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h9, 32'ha, 32'ha, 4'b0011, 1'b0};
    tbl[10] = '{3'd5, 3'b010, 1'b0, 5'd1, 5'd2, 32'ha5, 32'h5a, 32'h40, 32'h20c, 5'd21,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'ha5, 32'h5a, 32'h5a, 4'b0000, 1'b1};
    tbl[11] = '{3'd6, 3'b000, 1'b0, 5'd1, 5'd2, 32'h33, 32'h44, 32'h55, 32'h66, 5'd22,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0, 32'h44, 4'b0000, 1'b1};
    tbl[12] = '{3'd7, 3'b000, 1'b1, 5'd1, 5'd2, 32'h33, 32'h44, 32'h55, 32'h66, 5'd23,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h0, 32'h0, 32'h44, 4'b0000, 1'b1};
    tbl[13] = '{3'd0, 3'b000, 1'b0, 5'd5, 5'd7, 32'h11, 32'h22, 32'h0, 32'h0, 5'd24,
                1'b1, 5'd5, 32'haa, 1'b1, 5'd5, 32'hbb,
                (FWD ? 32'haa : 32'h11), 32'h22, 32'h22, 4'b0000, 1'b0};
    tbl[14] = '{3'd0, 3'b000, 1'b0, 5'd0, 5'd0, 32'h123, 32'h456, 32'h0, 32'h0, 5'd25,
                1'b1, 5'd0, 32'haa, 1'b1, 5'd0, 32'hbb, 32'h123, 32'h456, 32'h456, 4'b0000, 1'b0};
    tbl[15] = '{3'd0, 3'b000, 1'b1, 5'd3, 5'd9, 32'h31, 32'h32, 32'h0, 32'h0, 5'd26,
                1'b1, 5'd4, 32'haa, 1'b1, 5'd9, 32'hcc,
                32'h31, (FWD ? 32'hcc : 32'h32), (FWD ? 32'hcc : 32'h32), 4'b1000, 1'b0};
    tbl[16] = '{3'd1, 3'b001, 1'b0, 5'd6, 5'd6, 32'h61, 32'h62, 32'h3, 32'h0, 5'd27,
                1'b0, 5'd6, 32'he1, 1'b1, 5'd6, 32'he2,
                (FWD ? 32'he2 : 32'h61), 32'h3, (FWD ? 32'he2 : 32'h62), 4'b0001, 1'b0};
    tbl[17] = '{3'd5, 3'b111, 1'b0, 5'd10, 5'd11, 32'h71, 32'h72, 32'h0, 32'h300, 5'd0,
                1'b1, 5'd11, 32'hf0, 1'b1, 5'd10, 32'hf1,
                (FWD ? 32'hf1 : 32'h71), (FWD ? 32'hf0 : 32'h72), (FWD ? 32'hf0 : 32'h72),
                4'b0011, 1'b0};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive(tbl[0]);
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream: each new load overlaps the drain of the previous one.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i > 0) check_out($sformatf("vec%0d", i - 1));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      drive(tbl[i]);
      in_valid = 1'b1;
      out_ready = 1'b1;
      sb.push_back(to_exp(tbl[i]));
    end
    @(negedge clk);
    check_out("vec17");
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_hold_a", a_out, tbl[17].ea);

    // Stall with new input pending, then flush alongside in_valid.
    drive(tbl[0]);
    in_valid = 1'b1;
    out_ready = 1'b0;
    sb.push_back(to_exp(tbl[0]));
    @(negedge clk);
    chk("stall_load_valid", 32'(out_valid), 32'd1);
    drive(tbl[2]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_a", c), a_out, sb[0].a);
      chk($sformatf("stall%0d_b", c), b_out, sb[0].b);
      chk($sformatf("stall%0d_op", c), 32'(alu_op_out), 32'(sb[0].op));
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_held_valid", 32'(out_valid), 32'd0);
    sb.delete();
    drive(tbl[3]);
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_over_load_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;

    // Asynchronous reset while an instruction is held.
    drive(tbl[10]);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    chk("pre_reset_ill", 32'(illegal_out), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Issue stage directly upstream of the RV32I ALU. It takes decoded instruction fields and register-file read data, and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages. It selects the A/B operands, derives the 4-bit ALU opcode, and registers everything into the ID/EX pipeline register. A valid/ready handshake supports stall; a flush input supports branch redirect.

Parameters:
XLEN, 32, datapath width of operands and forwarded data
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage can accept an instruction this cycle
op_class  input  3  0=R-ALU, 1=I-ALU, 2=LUI, 3=AUIPC, 4=MEM addr, 5=BRANCH, 6/7 reserved
funct3  input  3  instruction bits 14:12
funct7_b30  input  1  instruction bit 30
rs1_addr  input  REG_ADDR_W  source 1 index
rs2_addr  input  REG_ADDR_W  source 2 index
rs1_data  input  XLEN  register-file read data 1
rs2_data  input  XLEN  register-file read data 2
imm  input  XLEN  sign-extended immediate, already formatted by the decoder
pc  input  XLEN  instruction PC
rd_in  input  REG_ADDR_W  destination index
exm_wr_en  input  1  EX/MEM result will be written back
exm_rd  input  REG_ADDR_W  EX/MEM destination
exm_data  input  XLEN  EX/MEM result
mwb_wr_en  input  1  MEM/WB write enable
mwb_rd  input  REG_ADDR_W  MEM/WB destination
mwb_data  input  XLEN  MEM/WB write data
flush  input  1  kill the held and incoming instruction
out_valid  output  1  registered operands valid
out_ready  input  1  EX stage consumes this cycle
a_out  output  XLEN  registered A operand (feeds ALU A_in)
b_out  output  XLEN  registered B operand (feeds ALU B_in)
alu_op_out  output  4  registered ALU opcode
rd_out  output  REG_ADDR_W  registered destination
rs2_fwd_out  output  XLEN  registered forwarded rs2 (store data / branch compare)
illegal_out  output  1  registered: reserved op_class was issued

Behaviour:
- Reset (rst_n low, asynchronous): every registered output, including out_valid, goes to 0. Reset mid-transfer drops the instruction.
- in_ready = !out_valid || out_ready. This is combinational and does not depend on in_valid.
- Load: when in_valid && in_ready && !flush, all output registers load on the next edge and out_valid=1. Latency is 1 cycle.
- Drain: when out_valid && out_ready && !(in_valid && in_ready), out_valid goes to 0. Data registers hold their values.
- Stall: when out_valid && !out_ready, all outputs hold bit-exact.
- Flush: when flush=1, out_valid=0 on the next edge regardless of other inputs. The incoming instruction is discarded. Flush takes priority over load.
- Forwarding is computed per source as follows:
  - If exm_wr_en, exm_rd!=0 and exm_rd==rsX_addr, use exm_data.
  - Else if mwb_wr_en, mwb_rd!=0 and mwb_rd==rsX_addr, use mwb_data.
  - Else use rsX_data.
  - When both stages match, EX/MEM wins. x0 is never forwarded.
- Operand and opcode selection by op_class (r1/r2 denote the forwarded values):
  - R-ALU: A=r1, B=r2, op={funct7_b30,funct3}.
  - I-ALU: A=r1, B=imm, op={funct7_b30 & (funct3==3'b101), funct3}. This makes SRAI=1101, and ADDI never becomes SUB.
  - LUI: A=0, B=imm, op=0000.
  - AUIPC: A=pc, B=imm, op=0000.
  - MEM: A=r1, B=imm, op=0000.
  - BRANCH: A=r1, B=r2. funct3 000/001 gives 1000 (SUB), 100/101 gives 0010 (SLT), 110/111 gives 0011 (SLTU), 010/011 gives 0000 with illegal_out=1.
  - Reserved op_class: A=B=0, op=0000, illegal_out=1.
- rs2_fwd_out = r2 for every class.
- All arithmetic is pure selection; no width change. Operands are XLEN throughout.

Optional Feature:
Macro ALU_FWD_EN.
- Defined: forwarding network as described above.
- Undefined: r1=rs1_data and r2=rs2_data unconditionally. The forwarding ports remain in the port list but are ignored. The pipeline must then resolve hazards by stalling upstream; this block adds no stall logic.

Test Plan:
- Reset: hold rst_n=0 mid-stream with out_valid=1 -> all outputs 0 immediately, with no clock edge required.
- R-type SUB: op_class=0, funct3=000, b30=1, rs1_data=10, rs2_data=3 -> one cycle later a_out=10, b_out=3, alu_op_out=1000, out_valid=1.
- Forward priority: rs1_addr=5, exm_rd=5 with exm_data=0xAA, mwb_rd=5 with mwb_data=0xBB, both write enables set -> a_out=0xAA. Repeat with exm_rd=0 and rs1_addr=0 -> a_out=rs1_data.
- I-type shift: op_class=1, funct3=101, b30=1 -> alu_op_out=1101. Same fields with funct3=000 -> 0000.
- Stall/flush: out_ready=0 for 3 cycles with new in_valid -> outputs unchanged and in_ready=0. Then flush=1 together with in_valid -> out_valid=0 next cycle.
- Branch BLTU: op_class=5, funct3=110 -> alu_op_out=0011. funct3=010 -> illegal_out=1.
